// File: rtl/az_gen_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | az_gen_pkg : shared types and defaults for the azimuth generator |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package az_gen_pkg;
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CONT    = 1'b1;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_DEPTH    = 1024;
endpackage
`default_nettype wire

// File: rtl/azimuth_pattern_generator_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | azimuth_pattern_generator_if : control, bank-write and output bus |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface azimuth_pattern_generator_if
  import az_gen_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DEPTH    = DEF_DEPTH
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                EN;
  logic                TRIG;
  logic                CLK_PE;
  logic                MODE;
  logic [ADDR_W:0]     LEN;
  logic                WR_EN;
  logic [ADDR_W-1:0]   WR_ADDR;
  logic [CHANNELS-1:0] WR_DATA;
  logic                SWAP_REQ;
  logic                SWAP_PENDING;
  logic                ACTIVE_BANK;
  logic                BUSY;
  logic                DONE;
  logic                TRIG_OVR;
  logic [CHANNELS-1:0] GEN_SIGNAL;

  modport master (
    output EN, TRIG, CLK_PE, MODE, LEN, WR_EN, WR_ADDR, WR_DATA, SWAP_REQ,
    input  SWAP_PENDING, ACTIVE_BANK, BUSY, DONE, TRIG_OVR, GEN_SIGNAL
  );

  modport slave (
    input  EN, TRIG, CLK_PE, MODE, LEN, WR_EN, WR_ADDR, WR_DATA, SWAP_REQ,
    output SWAP_PENDING, ACTIVE_BANK, BUSY, DONE, TRIG_OVR, GEN_SIGNAL
  );
endinterface
`default_nettype wire

// File: rtl/az_pattern_bank.sv
`default_nettype none
// +------------------------------------------------------------------+
// | az_pattern_bank : double-buffered sample store, write to shadow, |
// | read from active. Rev 1.0                                        |
// +------------------------------------------------------------------+
module az_pattern_bank
  import az_gen_pkg::*;
#(
  parameter  int CHANNELS = DEF_CHANNELS,
  parameter  int DEPTH    = DEF_DEPTH,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  wire logic                clk,
  input  wire logic                i_active_bank,
  input  wire logic                i_wr_en,
  input  wire logic [ADDR_W-1:0]   i_wr_addr,
  input  wire logic [CHANNELS-1:0] i_wr_data,
  input  wire logic [ADDR_W-1:0]   i_rd_addr,
  output      logic [CHANNELS-1:0] o_rd_data
);
  logic [CHANNELS-1:0] r_bank0 [DEPTH];
  logic [CHANNELS-1:0] r_bank1 [DEPTH];

  // Write target follows the bank select of the current cycle, so a write in
  // the same cycle as a swap still lands in the outgoing shadow bank.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      if (i_active_bank) r_bank0[i_wr_addr] <= i_wr_data;
      else               r_bank1[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = i_active_bank ? r_bank1[i_rd_addr] : r_bank0[i_rd_addr];
endmodule
`default_nettype wire

// File: rtl/azimuth_pattern_generator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | azimuth_pattern_generator : strobe-paced playback of a banked    |
// | multi-channel pattern, one-shot or continuous. Rev 1.0           |
// +------------------------------------------------------------------+
module azimuth_pattern_generator
  import az_gen_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DEPTH    = DEF_DEPTH
) (
  input wire logic                  SYS_CLK,
  input wire logic                  RST,
  azimuth_pattern_generator_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   c_depth   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   c_len_one = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_idx_one = ADDR_W'(1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_index;
  logic [ADDR_W:0]     r_len;
  logic                r_mode;
  logic                r_last_played;
  logic [CHANNELS-1:0] r_gen;
  logic                r_done;
  logic                r_trig_ovr;
  logic                r_active;
  logic                r_swap_pending;

  logic [CHANNELS-1:0] w_rd_data;
  logic [ADDR_W:0]     w_len_clamped;
  logic                w_start;
  logic                w_last;
  logic                w_wrap;
  logic                w_swap_apply;

  az_pattern_bank #(
    .CHANNELS (CHANNELS),
    .DEPTH    (DEPTH)
  ) u_bank (
    .clk           (SYS_CLK),
    .i_active_bank (r_active),
    .i_wr_en       (bus.WR_EN),
    .i_wr_addr     (bus.WR_ADDR),
    .i_wr_data     (bus.WR_DATA),
    .i_rd_addr     (r_index),
    .o_rd_data     (w_rd_data)
  );

  assign w_len_clamped = (bus.LEN > c_depth) ? c_depth : bus.LEN;
  assign w_start       = bus.EN && bus.TRIG && (bus.LEN != '0);
  assign w_last        = ({1'b0, r_index} == (r_len - c_len_one));
  assign w_wrap        = (r_state == RUN) && bus.EN && !w_start && bus.CLK_PE &&
                         !r_last_played && w_last && (r_mode == MODE_CONT);
  assign w_swap_apply  = r_swap_pending && ((r_state == IDLE) || w_start || w_wrap);

  // r_last_played marks that index LEN-1 has been output in one-shot mode;
  // the following strobe blanks the output and finishes.
  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      r_state        <= IDLE;
      r_index        <= '0;
      r_len          <= '0;
      r_mode         <= MODE_ONESHOT;
      r_last_played  <= 1'b0;
      r_gen          <= '0;
      r_done         <= 1'b0;
      r_trig_ovr     <= 1'b0;
      r_active       <= 1'b0;
      r_swap_pending <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_trig_ovr <= 1'b0;

      if (w_swap_apply) begin
        r_active       <= ~r_active;
        r_swap_pending <= 1'b0;
      end else if (bus.SWAP_REQ) begin
        r_swap_pending <= 1'b1;
      end

      if (!bus.EN) begin
        r_state       <= IDLE;
        r_index       <= '0;
        r_last_played <= 1'b0;
        r_gen         <= '0;
      end else if (w_start) begin
        r_state       <= RUN;
        r_index       <= '0;
        r_len         <= w_len_clamped;
        r_mode        <= bus.MODE;
        r_last_played <= 1'b0;
        r_trig_ovr    <= (r_state == RUN);
      end else if ((r_state == RUN) && bus.CLK_PE) begin
        if (r_last_played) begin
          r_state       <= IDLE;
          r_gen         <= '0;
          r_index       <= '0;
          r_last_played <= 1'b0;
          r_done        <= 1'b1;
        end else begin
          r_gen <= w_rd_data;
          if (!w_last)                  r_index       <= r_index + c_idx_one;
          else if (r_mode == MODE_CONT) r_index       <= '0;
          else                          r_last_played <= 1'b1;
        end
      end
    end
  end

  assign bus.GEN_SIGNAL   = r_gen;
  assign bus.BUSY         = (r_state == RUN);
  assign bus.DONE         = r_done;
  assign bus.TRIG_OVR     = r_trig_ovr;
  assign bus.ACTIVE_BANK  = r_active;
  assign bus.SWAP_PENDING = r_swap_pending;
endmodule
`default_nettype wire

// File: tb/tb_azimuth_pattern_generator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_azimuth_pattern_generator : directed vector table plus hand   |
// | sequences for reset, bank loading and length clamp. Rev 1.0      |
// +------------------------------------------------------------------+
module tb_azimuth_pattern_generator;
  import az_gen_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  azimuth_pattern_generator_if #(.CHANNELS(4), .DEPTH(1024)) bus ();

  azimuth_pattern_generator #(.CHANNELS(4), .DEPTH(1024)) dut (
    .SYS_CLK (clk),
    .RST     (rst),
    .bus     (bus)
  );

  typedef struct {
    logic        en;
    logic        mode;
    logic [10:0] len;
    logic        trig;
    logic        pe;
    logic        swap;
    int          gap;
    logic [3:0]  gen;
    logic        busy;
    logic        done;
    logic        ovr;
    logic        pend;
    logic        bank;
  } vec_t;

  vec_t tbl [0:47];
  int   nv = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt = 0;

  always @(posedge clk) if (bus.DONE) done_cnt <= done_cnt + 1;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input int en, input int mode, input int len, input int trig,
                     input int pe, input int swap, input int gap, input int gen,
                     input int busy, input int done, input int ovr, input int pend,
                     input int bank);
    tbl[nv].en   = en[0];
    tbl[nv].mode = mode[0];
    tbl[nv].len  = len[10:0];
    tbl[nv].trig = trig[0];
    tbl[nv].pe   = pe[0];
    tbl[nv].swap = swap[0];
    tbl[nv].gap  = gap;
    tbl[nv].gen  = gen[3:0];
    tbl[nv].busy = busy[0];
    tbl[nv].done = done[0];
    tbl[nv].ovr  = ovr[0];
    tbl[nv].pend = pend[0];
    tbl[nv].bank = bank[0];
    nv++;
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    v = tbl[i];
    bus.EN       = v.en;
    bus.MODE     = v.mode;
    bus.LEN      = v.len;
    bus.TRIG     = v.trig;
    bus.CLK_PE   = v.pe;
    bus.SWAP_REQ = v.swap;
    @(negedge clk);
    bus.TRIG     = 1'b0;
    bus.CLK_PE   = 1'b0;
    bus.SWAP_REQ = 1'b0;
    chk4($sformatf("vec%0d_gen", i),  bus.GEN_SIGNAL,   v.gen);
    chk1($sformatf("vec%0d_busy", i), bus.BUSY,         v.busy);
    chk1($sformatf("vec%0d_done", i), bus.DONE,         v.done);
    chk1($sformatf("vec%0d_ovr", i),  bus.TRIG_OVR,     v.ovr);
    chk1($sformatf("vec%0d_pend", i), bus.SWAP_PENDING, v.pend);
    chk1($sformatf("vec%0d_bank", i), bus.ACTIVE_BANK,  v.bank);
    repeat (v.gap) @(negedge clk);
  endtask

  task automatic wr(input logic [9:0] addr, input logic [3:0] data);
    bus.WR_EN   = 1'b1;
    bus.WR_ADDR = addr;
    bus.WR_DATA = data;
    @(negedge clk);
    bus.WR_EN   = 1'b0;
  endtask

  // Swap requested while idle: pending for one cycle, then applied.
  task automatic swap_idle(input logic exp_bank, input logic dbl);
    bus.SWAP_REQ = 1'b1;
    @(negedge clk);
    if (!dbl) bus.SWAP_REQ = 1'b0;
    chk1("swap_pend_set", bus.SWAP_PENDING, 1'b1);
    @(negedge clk);
    bus.SWAP_REQ = 1'b0;
    chk1("swap_bank", bus.ACTIVE_BANK, exp_bank);
    chk1("swap_pend_clr", bus.SWAP_PENDING, 1'b0);
    repeat (2) @(negedge clk);
    chk1("swap_bank_once", bus.ACTIVE_BANK, exp_bank);
    chk1("swap_pend_idle", bus.SWAP_PENDING, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_os, s_c, s_sw, s_rt, s_end;
    int n_pe;
    bit seen;

    bus.EN = 1'b1; bus.TRIG = 1'b0; bus.CLK_PE = 1'b0; bus.MODE = MODE_ONESHOT;
    bus.LEN = 11'd0; bus.WR_EN = 1'b0; bus.WR_ADDR = 10'd0; bus.WR_DATA = 4'd0;
    bus.SWAP_REQ = 1'b0;

    // one-shot LEN=4; MODE/LEN changed after TRIG must not matter
    s_os = nv;
    add(1,0,4, 1,0,0, 10, 0,1,0,0,0,1);
    add(1,1,2, 0,1,0, 99, 1,1,0,0,0,1);
    add(1,1,2, 0,1,0, 99, 2,1,0,0,0,1);
    add(1,1,2, 0,1,0, 99, 4,1,0,0,0,1);
    add(1,1,2, 0,1,0, 99, 8,1,0,0,0,1);
    add(1,1,2, 0,1,0, 20, 0,0,1,0,0,1);
    // continuous LEN=3, then EN dropped mid-run
    s_c = nv;
    add(1,1,3, 1,0,0, 10, 0,1,0,0,0,0);
    add(1,1,3, 0,1,0, 99, 15,1,0,0,0,0);
    add(1,1,3, 0,1,0, 99, 0,1,0,0,0,0);
    add(1,1,3, 0,1,0, 99, 5,1,0,0,0,0);
    add(1,1,3, 0,1,0, 99, 15,1,0,0,0,0);
    add(1,1,3, 0,1,0, 99, 0,1,0,0,0,0);
    add(1,1,3, 0,1,0, 99, 5,1,0,0,0,0);
    add(0,1,3, 0,0,0, 10, 0,0,0,0,0,0);
    // swap deferred to the wrap of a continuous LEN=2 pattern
    s_sw = nv;
    add(1,1,2, 1,0,0, 10, 0,1,0,0,0,1);
    add(1,1,2, 0,1,0, 49, 1,1,0,0,0,1);
    add(1,1,2, 0,0,1, 49, 1,1,0,0,1,1);
    add(1,1,2, 0,1,0, 99, 1,1,0,0,0,0);
    add(1,1,2, 0,1,0, 99, 2,1,0,0,0,0);
    add(1,1,2, 0,1,0, 99, 2,1,0,0,0,0);
    add(0,1,2, 0,0,0, 10, 0,0,0,0,0,0);
    // retrigger, TRIG+CLK_PE together, then ignored triggers
    s_rt = nv;
    add(1,0,8, 1,0,0, 10, 0,1,0,0,0,1);
    add(1,0,8, 0,1,0, 99, 1,1,0,0,0,1);
    add(1,0,8, 0,1,0, 99, 2,1,0,0,0,1);
    add(1,0,8, 1,0,0, 10, 2,1,0,1,0,1);
    add(1,0,8, 0,1,0, 99, 1,1,0,0,0,1);
    add(1,0,8, 0,1,0, 99, 2,1,0,0,0,1);
    add(1,0,8, 1,1,0, 99, 2,1,0,1,0,1);
    add(1,0,8, 0,1,0, 99, 1,1,0,0,0,1);
    add(0,0,8, 0,0,0, 10, 0,0,0,0,0,1);
    add(1,0,0, 1,0,0, 10, 0,0,0,0,0,1);
    add(0,0,8, 1,0,0, 10, 0,0,0,0,0,1);
    s_end = nv;

    // reset state
    repeat (3) @(negedge clk);
    chk4("rst_gen",  bus.GEN_SIGNAL, 4'd0);
    chk1("rst_busy", bus.BUSY, 1'b0);
    chk1("rst_done", bus.DONE, 1'b0);
    chk1("rst_ovr",  bus.TRIG_OVR, 1'b0);
    chk1("rst_bank", bus.ACTIVE_BANK, 1'b0);
    chk1("rst_pend", bus.SWAP_PENDING, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    wr(10'd0, 4'h1); wr(10'd1, 4'h2); wr(10'd2, 4'h4); wr(10'd3, 4'h8);
    swap_idle(1'b1, 1'b0);
    for (int i = s_os; i < s_c; i++) apply_vec(i);
    chkn("oneshot_done_count", done_cnt, 1);

    wr(10'd0, 4'hF); wr(10'd1, 4'h0); wr(10'd2, 4'h5);
    swap_idle(1'b0, 1'b0);
    for (int i = s_c; i < s_sw; i++) apply_vec(i);
    chkn("cont_done_count", done_cnt, 1);

    wr(10'd0, 4'h1); wr(10'd1, 4'h1);
    swap_idle(1'b1, 1'b0);
    wr(10'd0, 4'h2); wr(10'd1, 4'h2);
    for (int i = s_sw; i < s_rt; i++) apply_vec(i);

    for (int a = 0; a < 8; a++) wr(a[9:0], 4'(a + 1));
    swap_idle(1'b1, 1'b1);
    for (int i = s_rt; i < s_end; i++) apply_vec(i);
    chkn("edge_done_count", done_cnt, 1);

    // asynchronous reset in the middle of playback
    bus.EN = 1'b1; bus.MODE = MODE_ONESHOT; bus.LEN = 11'd8;
    bus.TRIG = 1'b1; @(negedge clk); bus.TRIG = 1'b0;
    repeat (2) begin
      repeat (9) @(negedge clk);
      bus.CLK_PE = 1'b1; @(negedge clk); bus.CLK_PE = 1'b0;
    end
    chk4("prerst_gen", bus.GEN_SIGNAL, 4'd2);
    #2 rst = 1'b1;
    #1;
    chk4("arst_gen",  bus.GEN_SIGNAL, 4'd0);
    chk1("arst_busy", bus.BUSY, 1'b0);
    chk1("arst_bank", bus.ACTIVE_BANK, 1'b0);
    chk1("arst_done", bus.DONE, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chkn("arst_done_count", done_cnt, 1);
    chk1("arst_busy_after", bus.BUSY, 1'b0);

    // LEN beyond DEPTH clamps to 1024 samples; banks survive reset
    bus.LEN = 11'd2000;
    bus.TRIG = 1'b1; @(negedge clk); bus.TRIG = 1'b0;
    @(negedge clk);
    n_pe = 0;
    seen = 1'b0;
    for (int k = 1; k <= 1100; k++) begin
      if (!seen) begin
        bus.CLK_PE = 1'b1; @(negedge clk); bus.CLK_PE = 1'b0;
        n_pe = k;
        if (k == 1) chk4("clamp_first_sample", bus.GEN_SIGNAL, 4'd2);
        if (bus.DONE) seen = 1'b1;
        @(negedge clk);
      end
    end
    chk1("clamp_done_seen", seen, 1'b1);
    chkn("clamp_strobe_count", n_pe, 1025);
    chk1("clamp_idle", bus.BUSY, 1'b0);
    chkn("final_done_count", done_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
